// File: rtl/debounced_counter_display_pkg.sv
// Shared constants for the debounced counter display.
// Glyphs are {a,b,c,d,e,f,g}, active-low.
package debounced_counter_display_pkg;

  localparam logic [7:0] ANODE_OFF = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  function automatic logic [6:0] hex_glyph(
    input logic [3:0] v
  );
    logic [6:0] s;
    unique case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/debounced_counter_display_button_debouncer.sv
// Button debouncer: 2-flop sync, stability tally,
// and a one-cycle pulse on each accepted press.
module button_debouncer
  import debounced_counter_display_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int TW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] LAST =
    TW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync;
  logic          stable;
  logic [TW-1:0] tally;

  // bring the raw button into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], raw};
  end

  // accept a new level after an unbroken run of disagreement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      tally  <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync[1] != stable) begin
        if (tally == LAST) begin
          stable <= sync[1];
          tally  <= '0;
          press  <= sync[1];
        end else begin
          tally <= tally + TW'(1);
        end
      end else begin
        tally <= '0;
      end
    end
  end

endmodule

// File: rtl/debounced_counter_display.sv
// Up/down step counter driven by a debounced button,
// shown on a multiplexed active-low 7-segment display.
module debounced_counter_display
  import debounced_counter_display_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DEBOUNCE_TICKS = 1_000_000,
  parameter int REFRESH_TICKS  = 100_000,
  parameter int SATURATE       = 0
) (
  input  logic                clk,
  input  logic                reset_button,
  input  logic                db_button,
  input  logic                sw_uhdl,
  input  logic                sw_clear,
  output logic [4*DIGITS-1:0] count,
  output logic                limit_pulse,
  output logic [7:0]          anode,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                e,
  output logic                f,
  output logic                g
);

  localparam int CW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_TICKS + 1);
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);
  localparam logic [RW-1:0] LAST_TICK =
    RW'(REFRESH_TICKS - 1);

  logic          press;
  logic [1:0]    up_sync;
  logic [1:0]    clr_sync;
  logic [RW-1:0] refresh;
  logic [IW-1:0] digit;
  logic [3:0]    nibble;

  button_debouncer #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_button (
    .clk  (clk),
    .rst  (reset_button),
    .raw  (db_button),
    .press(press)
  );

  // synchronise the static switches
  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      up_sync  <= '0;
      clr_sync <= '0;
    end else begin
      up_sync  <= {up_sync[0], sw_uhdl};
      clr_sync <= {clr_sync[0], sw_clear};
    end
  end

  // step the count; clear overrides any press
  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      count       <= '0;
      limit_pulse <= 1'b0;
    end else begin
      limit_pulse <= 1'b0;
      if (clr_sync[1]) begin
        count <= '0;
      end else if (press) begin
        if (up_sync[1]) begin
          if (count == MAX) begin
            limit_pulse <= 1'b1;
            if (SATURATE == 0) count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end else begin
          if (count == '0) begin
            limit_pulse <= 1'b1;
            if (SATURATE == 0) count <= MAX;
          end else begin
            count <= count - CW'(1);
          end
        end
      end
    end
  end

  // scan through the active digits
  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      refresh <= '0;
      digit   <= '0;
    end else if (refresh == LAST_TICK) begin
      refresh <= '0;
      if (digit == LAST_DIGIT) digit <= '0;
      else                     digit <= digit + IW'(1);
    end else begin
      refresh <= refresh + RW'(1);
    end
  end

  // decode the active digit straight from registered state
  always_comb begin
    anode  = ANODE_OFF ^ (8'(1) << digit);
    nibble = 4'(count >> {digit, 2'b00});
    {a, b, c, d, e, f, g} = hex_glyph(nibble);
  end

endmodule

// File: tb/tb_debounced_counter_display.sv
// Directed bench: wrap, saturate and 1-digit instances
// share one stimulus; expected values are hand-computed.
module tb_debounced_counter_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic up  = 1'b1;
  logic clr = 1'b0;

  logic [15:0] cnt_w, cnt_s;
  logic [3:0]  cnt_o;
  logic        lim_w, lim_s, lim_o;
  logic [7:0]  an_w, an_s, an_o;
  logic [6:0]  seg_w, seg_s, seg_o;

  debounced_counter_display #(
    .DIGITS(4), .DEBOUNCE_TICKS(4),
    .REFRESH_TICKS(2), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .reset_button(rst), .db_button(btn),
    .sw_uhdl(up), .sw_clear(clr), .count(cnt_w),
    .limit_pulse(lim_w), .anode(an_w),
    .a(seg_w[6]), .b(seg_w[5]), .c(seg_w[4]),
    .d(seg_w[3]), .e(seg_w[2]), .f(seg_w[1]),
    .g(seg_w[0])
  );

  debounced_counter_display #(
    .DIGITS(4), .DEBOUNCE_TICKS(4),
    .REFRESH_TICKS(2), .SATURATE(1)
  ) u_sat (
    .clk(clk), .reset_button(rst), .db_button(btn),
    .sw_uhdl(up), .sw_clear(clr), .count(cnt_s),
    .limit_pulse(lim_s), .anode(an_s),
    .a(seg_s[6]), .b(seg_s[5]), .c(seg_s[4]),
    .d(seg_s[3]), .e(seg_s[2]), .f(seg_s[1]),
    .g(seg_s[0])
  );

  debounced_counter_display #(
    .DIGITS(1), .DEBOUNCE_TICKS(4),
    .REFRESH_TICKS(2), .SATURATE(1)
  ) u_one (
    .clk(clk), .reset_button(rst), .db_button(btn),
    .sw_uhdl(up), .sw_clear(clr), .count(cnt_o),
    .limit_pulse(lim_o), .anode(an_o),
    .a(seg_o[6]), .b(seg_o[5]), .c(seg_o[4]),
    .d(seg_o[3]), .e(seg_o[2]), .f(seg_o[1]),
    .g(seg_o[0])
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int k;
  int nw, ns, no;
  logic [15:0] snap_w, snap_s;
  logic [3:0]  snap_o;
  logic [6:0]  glyph [16];

  typedef struct {
    logic        up;
    logic        clr;
    logic [15:0] ew;
    logic [15:0] es;
    logic [3:0]  eo;
    int          lw;
    int          ls;
    int          lo;
  } vec_t;

  vec_t vecs [11];

  // cycles since reset release, for the scan model
  always @(posedge clk or posedge rst)
    if (rst) k <= 0;
    else     k <= k + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    nw += int'(lim_w);
    ns += int'(lim_s);
    no += int'(lim_o);
  endtask

  task automatic press(input logic dir, input logic c);
    up = dir;
    repeat (3) tick();
    btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4 && c) clr = 1'b1;
      if (i == 7) begin
        snap_w = cnt_w;
        snap_s = cnt_s;
        snap_o = cnt_o;
      end
    end
    btn = 1'b0;
    repeat (10) tick();
    clr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic scan_check(input logic [15:0] mw,
                            input logic [15:0] ms,
                            input logic [3:0]  mo);
    int idx;
    logic [3:0] nw_nib, ns_nib;
    logic [7:0] an;
    for (int j = 0; j < 8; j++) begin
      tick();
      idx = (k / 2) % 4;
      an = ~(8'd1 << idx);
      nw_nib = 4'(mw >> (4 * idx));
      ns_nib = 4'(ms >> (4 * idx));
      chk("scan_wrap", {an_w, seg_w}, {an, glyph[nw_nib]});
      chk("scan_sat", {an_s, seg_s}, {an, glyph[ns_nib]});
      chk("scan_one", {an_o, seg_o}, {8'hFE, glyph[mo]});
    end
  endtask

  task automatic chk_all(input string name,
                         input logic [15:0] w,
                         input logic [15:0] s,
                         input logic [3:0]  o);
    chk({name, "_wrap"}, cnt_w, w);
    chk({name, "_sat"},  cnt_s, s);
    chk({name, "_one"},  cnt_o, o);
  endtask

  task automatic chk_reset_out(input string name);
    chk_all(name, 16'h0, 16'h0, 4'h0);
    chk({name, "_lim"}, {lim_w, lim_s, lim_o}, 3'b000);
    chk({name, "_disp_wrap"}, {an_w, seg_w}, {8'hFE, 7'h01});
    chk({name, "_disp_sat"},  {an_s, seg_s}, {8'hFE, 7'h01});
    chk({name, "_disp_one"},  {an_o, seg_o}, {8'hFE, 7'h01});
  endtask

  initial begin
    logic [9:0] pat;
    glyph = '{7'h01, 7'h4F, 7'h12, 7'h06,
              7'h4C, 7'h24, 7'h20, 7'h0F,
              7'h00, 7'h04, 7'h08, 7'h60,
              7'h31, 7'h42, 7'h30, 7'h38};
    vecs[0]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0, 4'h0, 1, 1, 1};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 16'h1, 4'h1, 1, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0, 4'h0, 1, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 16'hFFFE, 16'h0, 4'h0, 0, 1, 1};
    vecs[4]  = '{1'b1, 1'b0, 16'hFFFF, 16'h1, 4'h1, 0, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'h2, 4'h2, 1, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0001, 16'h3, 4'h3, 0, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0002, 16'h4, 4'h4, 0, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 16'h0003, 16'h5, 4'h5, 0, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 16'h0000, 16'h0, 4'h0, 0, 0, 0};
    vecs[10] = '{1'b1, 1'b0, 16'h0001, 16'h1, 4'h1, 0, 0, 0};
    nw = 0; ns = 0; no = 0;

    // reset state, during and right after
    repeat (3) tick();
    chk_reset_out("in_reset");
    rst = 1'b0;
    tick();
    chk_reset_out("post_reset");

    // glitchy press: single step only
    up = 1'b1;
    repeat (3) tick();
    pat = 10'b11_1111_1101;
    for (int i = 0; i < 10; i++) begin
      btn = pat[i];
      tick();
    end
    btn = 1'b0;
    repeat (12) tick();
    chk_all("glitch_press", 16'h1, 16'h1, 4'h1);

    // pulse shorter than the window is ignored
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    repeat (10) tick();
    chk_all("short_pulse", 16'h1, 16'h1, 4'h1);

    // reset mid-debounce, button held through release
    btn = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_all("mid_rst", 16'h0, 16'h0, 4'h0);
    rst = 1'b0;
    repeat (5) tick();
    chk_all("rst_window", 16'h0, 16'h0, 4'h0);
    repeat (5) tick();
    chk_all("rst_press", 16'h1, 16'h1, 4'h1);
    btn = 1'b0;
    repeat (10) tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // table of single presses
    for (int i = 0; i < 11; i++) begin
      nw = 0; ns = 0; no = 0;
      press(vecs[i].up, vecs[i].clr);
      chk_all($sformatf("vec%0d", i),
              vecs[i].ew, vecs[i].es, vecs[i].eo);
      chk($sformatf("vec%0d_lim_wrap", i), nw, vecs[i].lw);
      chk($sformatf("vec%0d_lim_sat", i),  ns, vecs[i].ls);
      chk($sformatf("vec%0d_lim_one", i),  no, vecs[i].lo);
      if (vecs[i].clr) begin
        chk("clr_vs_press_wrap", snap_w, 16'h0);
        chk("clr_vs_press_sat",  snap_s, 16'h0);
        chk("clr_vs_press_one",  snap_o, 4'h0);
      end
      if (i == 3 || i == 8)
        scan_check(vecs[i].ew, vecs[i].es, vecs[i].eo);
    end

    // climb the 1-digit counter to its max
    nw = 0; ns = 0; no = 0;
    for (int i = 0; i < 14; i++) press(1'b1, 1'b0);
    chk_all("climb", 16'hF, 16'hF, 4'hF);
    chk("climb_lim", nw + ns + no, 0);

    // saturate at max on the 1-digit counter
    nw = 0; ns = 0; no = 0;
    press(1'b1, 1'b0);
    chk_all("sat_max", 16'h10, 16'h10, 4'hF);
    chk("sat_max_lim_one", no, 1);
    chk("sat_max_lim_4d", nw + ns, 0);
    scan_check(16'h10, 16'h10, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounced_counter_display.md
DEBOUNCED_COUNTER_DISPLAY -- requirements
Module: debounced_counter_display

Interface
REQ-001 Parameter DIGITS, default 8: number of active hex digits, legal range 1..8.
REQ-002 Parameter DEBOUNCE_TICKS, default 1_000_000: consecutive stable clk cycles required to accept a button level change.
REQ-003 Parameter REFRESH_TICKS, default 100_000: clk cycles each digit is driven before the scan advances.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at limits; 1 = hold at limits.
REQ-005 clk  in  1  single system clock; all state on its rising edge.
REQ-006 reset_button  in  1  asynchronous, active-high reset.
REQ-007 db_button  in  1  raw, bouncing, asynchronous step button, active-high.
REQ-008 sw_uhdl  in  1  direction: 1 = count up, 0 = count down; static switch, synchronised internally.
REQ-009 sw_clear  in  1  synchronous clear request, level-sensitive, synchronised internally.
REQ-010 count  out  4*DIGITS  current count value.
REQ-011 limit_pulse  out  1  one-cycle flag on any wrap or saturation event.
REQ-012 anode  out  8  digit enables, active-low.
REQ-013 a, b, c, d, e, f, g  out  1 each  segment drives, active-low.

Function
REQ-014 db_button, sw_uhdl and sw_clear SHALL each pass through a 2-flop synchroniser before any use.
REQ-015 The debouncer SHALL update its stable level only after the synchronised input differs from it for DEBOUNCE_TICKS consecutive cycles; any agreeing cycle SHALL restart the tally.
REQ-016 A stable-level 0->1 transition SHALL produce exactly one 1-cycle press pulse; release SHALL produce none.
REQ-017 The press pulse SHALL change count by exactly 1 on the next clk edge: +1 if synchronised sw_uhdl=1, -1 if 0.
REQ-018 Count arithmetic SHALL be unsigned modulo 2^(4*DIGITS).
REQ-019 SATURATE=0: up from max SHALL give 0, down from 0 SHALL give max; limit_pulse SHALL assert for that cycle.
REQ-020 SATURATE=1: up at max or down at 0 SHALL leave count unchanged and SHALL assert limit_pulse for one cycle.
REQ-021 Synchronised sw_clear=1 SHALL force count to 0 each cycle, SHALL take priority over a coincident press, and SHALL not assert limit_pulse.
REQ-022 Scan FSM: digit index 0..DIGITS-1, advancing every REFRESH_TICKS cycles and wrapping from DIGITS-1 to 0; DIGITS=1 stays at 0.
REQ-023 anode[i] SHALL be 0 only when i equals the digit index; anode bits DIGITS..7 SHALL always be 1.
REQ-024 Segments SHALL show hex nibble count[4i+3:4i] of the active digit, standard 0-F glyphs, active-low, changing in the same cycle as anode.
REQ-025 A count change mid-scan SHALL appear on the next displayed digit with no extra latency (combinational decode from registered count and index).

Reset
REQ-026 While reset_button=1: count=0, limit_pulse=0, debounce stable level=0, debounce tally=0, synchronisers=0, digit index=0, refresh counter=0.
REQ-027 Outputs during and right after reset: anode=8'hFE; a..f=0, g=1 (glyph "0").
REQ-028 Reset asserted mid-debounce or mid-scan SHALL discard all progress; a button held through reset release SHALL need a full DEBOUNCE_TICKS window and SHALL then generate one press.

Structure
REQ-029 Shared package: 7-segment glyph constants for 0-F and the anode-off constant 8'hFF.
REQ-030 One sub-module, button_debouncer (synchroniser, tally, stable level, rising-edge pulse), parameterised by DEBOUNCE_TICKS.
REQ-031 Counter width and tally widths SHALL derive from parameters via $clog2; no fixed magic widths.

Verification (DIGITS=4, DEBOUNCE_TICKS=4, REFRESH_TICKS=2)
REQ-032 Press held 10 cycles with 1-cycle glitches in the first 3, sw_uhdl=1 -> count 0->1 once, no second step.
REQ-033 count=16'hFFFF, SATURATE=0, clean up-press -> count=0, limit_pulse high 1 cycle; SATURATE=1 -> count stays FFFF, limit_pulse high 1 cycle.
REQ-034 count=0, sw_uhdl=0, press -> 16'hFFFF (wrap) / 0 (saturate), limit_pulse high 1 cycle.
REQ-035 count=16'h1A3F, free run 8 cycles -> anode sequence FE,FE,FD,FD,FB,FB,F7,F7 with glyphs F,3,A,1; anode[7:4] never 0.
REQ-036 sw_clear and press coincide at count=5 -> count=0, limit_pulse=0; reset pulse mid-debounce -> count unchanged from 0, no press until 4 new stable cycles.
